// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/memory handshake and datapath control bundle for control_sequencer.
interface control_sequencer_if #(
   parameter int INSTR_W = 16,
   parameter int BEAT_W  = 3
);
   logic [INSTR_W-1:0] instruction;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_we;
   logic [4:0]         state;
   logic [BEAT_W-1:0]  beat;
   logic               retire;
   logic               halted;
   modport master (input instruction, mem_ready, output mem_req, mem_we, state, beat, retire, halted);
   modport slave  (output instruction, mem_ready, input mem_req, mem_we, state, beat, retire, halted);
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-beat fetch/decode/execute control FSM with memory stalls and retire pulse.
// Opcodes: NOP 00000, MULTIPLY 00100, JUMP 01111, LOAD 10000, STORE 10001, MOVE 10010, HALT 11111;
// src: REGISTER 00, IMMEDIATE 01, MEMORY 10. Define CTRL_TRAP_EN to route illegal opcodes through S_TRAP.
module control_sequencer #(
   parameter int INSTR_W     = 16,
   parameter int FETCH_BEATS = 2,
   parameter int ADDR_BEATS  = 2,
   parameter int BEAT_W      = 3
) (
   input logic clock,
   input logic reset,
   control_sequencer_if.master bus
);
   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_DECODE, S_ALU_REG, S_ALU_IMM, S_FETCH_IMM, S_STORE_RESULT, S_COPY_REG,
      S_FETCH_ADDR, S_MEM_READ, S_MEM_WRITE, S_MOVE_READ, S_FETCH_ADDR2, S_MOVE_WRITE, S_JUMP_ADDR,
      S_EXEC_JUMP, S_HALT, S_TRAP
   } state_t;
   localparam logic [4:0] OP_NOP = 5'b00000, OP_MUL = 5'b00100, OP_JUMP = 5'b01111, OP_LOAD = 5'b10000,
                          OP_STORE = 5'b10001, OP_MOVE = 5'b10010, OP_HALT = 5'b11111;
   localparam logic [1:0] SRC_REG = 2'b00, SRC_IMM = 2'b01, SRC_MEM = 2'b10;
`ifdef CTRL_TRAP_EN
   localparam state_t S_ILLEGAL = S_TRAP;
`else
   localparam state_t S_ILLEGAL = S_HALT;
`endif
   state_t state, ns;
   logic [BEAT_W-1:0] beat, nb;
   logic retire, nret;
   logic [4:0] op;
   logic [1:0] src;
   logic mem, last, done;
   int lim;
   logic unused;
   assign unused = ^bus.instruction[INSTR_W-8:0];
   assign op  = bus.instruction[INSTR_W-1 -: 5];
   assign src = bus.instruction[INSTR_W-6 -: 2];
   always_comb begin
      mem = state inside {S_FETCH, S_FETCH_IMM, S_FETCH_ADDR, S_FETCH_ADDR2, S_JUMP_ADDR, S_MEM_READ,
                          S_MEM_WRITE, S_MOVE_READ, S_MOVE_WRITE, S_STORE_RESULT};
      lim = state == S_FETCH ? FETCH_BEATS :
            state == S_STORE_RESULT ? (op == OP_MUL ? 2 : 1) :
            state inside {S_FETCH_IMM, S_FETCH_ADDR, S_FETCH_ADDR2, S_JUMP_ADDR} ? ADDR_BEATS : 1;
      last = beat == BEAT_W'(lim - 1);
      done = (!mem || bus.mem_ready) && last;
      nb = (!mem || bus.mem_ready) ? (last ? '0 : beat + 1'b1) : beat;
      ns = state;
      case (state)
         S_RESET: ns = S_FETCH;
         S_FETCH: if (done) ns = S_DECODE;
         S_DECODE:
            if (op == OP_NOP) ns = S_FETCH;
            else if (op == OP_JUMP) ns = S_JUMP_ADDR;
            else if (!op[4] && op != 5'b01101 && op != 5'b01110) ns = src == SRC_REG ? S_ALU_REG : S_FETCH_IMM;
            else if (op == OP_LOAD)
               ns = src == SRC_REG ? S_COPY_REG : src == SRC_IMM ? S_FETCH_IMM : src == SRC_MEM ? S_FETCH_ADDR : S_ILLEGAL;
            else if (op == OP_STORE || op == OP_MOVE) ns = S_FETCH_ADDR;
            else if (op == OP_HALT) ns = S_HALT;
            else ns = S_ILLEGAL;
         S_FETCH_IMM: if (done) ns = op == OP_LOAD ? S_FETCH : S_ALU_IMM;
         S_ALU_REG, S_ALU_IMM: ns = S_STORE_RESULT;
         S_FETCH_ADDR: if (done) ns = op == OP_LOAD ? S_MEM_READ : op == OP_STORE ? S_MEM_WRITE : S_MOVE_READ;
         S_MOVE_READ: if (done) ns = S_FETCH_ADDR2;
         S_FETCH_ADDR2: if (done) ns = S_MOVE_WRITE;
         S_JUMP_ADDR: if (done) ns = S_EXEC_JUMP;
         S_COPY_REG, S_EXEC_JUMP: ns = S_FETCH;
         S_MEM_READ, S_MEM_WRITE, S_MOVE_WRITE, S_STORE_RESULT: if (done) ns = S_FETCH;
         S_TRAP: ns = S_JUMP_ADDR;
         default: ns = state;
      endcase
      // Every entry into FETCH other than from reset completes an instruction.
      nret = ns == S_FETCH && state != S_RESET && state != S_FETCH;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_RESET;
         beat   <= '0;
         retire <= 1'b0;
      end else begin
         state  <= ns;
         beat   <= nb;
         retire <= nret;
      end
   end
   assign bus.state   = state;
   assign bus.beat    = beat;
   assign bus.retire  = retire;
   assign bus.halted  = state == S_HALT;
   assign bus.mem_req = mem;
   assign bus.mem_we  = state inside {S_MEM_WRITE, S_MOVE_WRITE, S_STORE_RESULT};
endmodule
